note_tone: RTL and testbench
============================

Name: note_tone

Overview:
- Tone generator stage directly downstream of the note sequencer.
- Consumes the sequencer's `notenum` and `run`, and drives the piezo pin `pz` with a square wave at the selected pitch.
- Replaces the free-running divider with a glitch-free generator: pitch changes and stops take effect only at full-period boundaries, so the piezo never sees a truncated half-cycle.
- Single clock domain (`clk`), with synchronous active-high reset `clr`.

Parameters:
- DIV, 1, prescale factor. The tone counter advances once every DIV clk cycles. The half-period table is in ticks for a 1 MHz tick, so set DIV = f_clk / 1 MHz.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- clr  input  1  synchronous active-high reset
- run  input  1  sequencer playing; 1 = sound requested
- notenum  input  4  note code: 1..13 = C4..C5 chromatic; 0, 14, 15 = rest
- pz  output  1  piezo drive square wave
- active  output  1  high while in TONE state
- per_done  output  1  one-clk pulse at every end-of-low-half boundary in TONE

Behaviour:
Reset:
- `clr` high at a rising edge forces: pz=0, active=0, per_done=0, state=IDLE, cur_note=0, cnt=0, prescaler=0.
- `clr` has priority over every other event, including mid-tone; pz drops on that same edge.

Tick:
- Prescaler counts 0..DIV-1, wrapping to 0. `tick` = (prescaler==DIV-1).
- For DIV=1, tick is high every cycle.
- The prescaler free-runs whenever `clr` is low.

Half-period table (ticks), HALF(n), notes 1..13:
- 1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012, 956.
- Implemented as an 11-bit constant ROM indexed by `cur_note`.

valid(n):
- valid(n) = (n>=1 && n<=13).

State IDLE:
- Outputs: pz=0, active=0.
- On a tick with run && valid(notenum): cur_note<=notenum, cnt<=HALF(notenum)-1, pz<=1, state<=TONE.
- Latency from that tick to pz=1 is one clk edge.
- run with a rest code stays in IDLE.

State TONE (active=1), on each tick:
- If cnt != 0: cnt decrements.
- If cnt==0 and pz==1 (end of high half): pz<=0, cnt<=HALF(cur_note)-1. No inputs are sampled here.
- If cnt==0 and pz==0 (end of low half, i.e. period boundary):
  - per_done<=1 for exactly one clk.
  - If run && valid(notenum): cur_note<=notenum, cnt<=HALF(notenum)-1, pz<=1.
  - Otherwise: state<=IDLE, pz stays 0.

Boundary rules:
- Input changes during a period are ignored. Every started period completes both halves with the old pitch.
- The high half and low half are each exactly HALF(cur_note) ticks.
- `notenum` changing at the same edge as the boundary tick is sampled with its new value.
- A back-to-back same note produces a continuous wave with no gap.
- Non-tick cycles hold all state; per_done is 0 on them.

Widths:
- cnt is 11 bits. The maximum value 1910 fits, so no wrap is possible.

Test Plan:
- DIV=1, clr high then low, run=0 -> pz=0, active=0, per_done=0 for 100 cycles.
- DIV=1, run=1, notenum=10 -> pz rises 1 clk after sampling, high 1136 clk, low 1136 clk; per_done pulses every 2272 clk; active=1.
- DIV=1, notenum 10 -> 1 set 500 clk into a high half -> current period finishes 1136/1136, then pz runs 1911 high / 1911 low, with no short pulse.
- DIV=1, run dropped 100 clk into high half of note 13 -> high completes at 956, low 956, one per_done pulse, then active=0, pz=0.
- DIV=1, run=1 with notenum=0, then 14, then 15 -> stays IDLE, pz=0. Later notenum=5 -> tone with 1517/1517.
- DIV=4, note 13 -> high 3824 clk, low 3824 clk.
- Same setup, clr asserted mid-high -> pz=0 and active=0 on that edge; restart after release behaves as from reset.

Source files
------------

// File: rtl/note_tone.sv
// Glitch-free square-wave tone generator for the piezo, driven by the note sequencer.
// Pitch changes and stops take effect only at full-period boundaries.
module note_tone #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [3:0] notenum,
  output logic       pz,
  output logic       active,
  output logic       per_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic {IDLE, TONE} state_t;

  state_t        state;
  logic [3:0]    cur_note;
  logic [10:0]   cnt;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic          start_ok;

  // Half-period in 1 MHz ticks for C4..C5; rest codes never reach the loader.
  function automatic logic [10:0] half(input logic [3:0] n);
    case (n)
      4'd1:    half = 11'd1911;
      4'd2:    half = 11'd1804;
      4'd3:    half = 11'd1703;
      4'd4:    half = 11'd1607;
      4'd5:    half = 11'd1517;
      4'd6:    half = 11'd1432;
      4'd7:    half = 11'd1351;
      4'd8:    half = 11'd1276;
      4'd9:    half = 11'd1204;
      4'd10:   half = 11'd1136;
      4'd11:   half = 11'd1073;
      4'd12:   half = 11'd1012;
      4'd13:   half = 11'd956;
      default: half = 11'd1;
    endcase
  endfunction

  assign tick     = (prescaler == PMAX);
  assign start_ok = run && (notenum >= 4'd1) && (notenum <= 4'd13);

  // Inputs are only looked at when idle or at the end of a low half.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      pz        <= 1'b0;
      active    <= 1'b0;
      per_done  <= 1'b0;
      cur_note  <= 4'd0;
      cnt       <= 11'd0;
      prescaler <= '0;
    end else begin
      per_done  <= 1'b0;
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              cur_note <= notenum;
              cnt      <= half(notenum) - 11'd1;
              pz       <= 1'b1;
              active   <= 1'b1;
              state    <= TONE;
            end
          end
          TONE: begin
            if (cnt != 11'd0) begin
              cnt <= cnt - 11'd1;
            end else if (pz) begin
              pz  <= 1'b0;
              cnt <= half(cur_note) - 11'd1;
            end else begin
              per_done <= 1'b1;
              if (start_ok) begin
                cur_note <= notenum;
                cnt      <= half(notenum) - 11'd1;
                pz       <= 1'b1;
              end else begin
                state  <= IDLE;
                active <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The wave is never driven outside TONE, and boundaries are isolated pulses.
  assert property (@(posedge clk) pz |-> active);
  assert property (@(posedge clk) disable iff (clr) per_done |=> !per_done);
  assert property (@(posedge clk) cnt <= 11'd1910);

endmodule

// File: tb/tb_note_tone.sv
// Directed bench for note_tone: a DIV=1 instance for pitch/boundary behaviour
// and a DIV=4 instance for prescaling and mid-tone reset.
module tb_note_tone;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, run;
  logic [3:0] notenum;
  logic       pz, active, per_done;
  logic       clr4, run4;
  logic [3:0] notenum4;
  logic       pz4, active4, per_done4;

  note_tone #(.DIV(1)) dut (
    .clk(clk), .clr(clr), .run(run), .notenum(notenum),
    .pz(pz), .active(active), .per_done(per_done)
  );

  note_tone #(.DIV(4)) dut4 (
    .clk(clk), .clr(clr4), .run(run4), .notenum(notenum4),
    .pz(pz4), .active(active4), .per_done(per_done4)
  );

  typedef struct {
    logic       run;
    logic [3:0] notenum;
    int         half;
  } vec_t;

  vec_t vecs [9];
  int   total  = 0;
  int   passed = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic logic pz_of(input bit sel);
    return sel ? pz4 : pz;
  endfunction

  function automatic logic act_of(input bit sel);
    return sel ? active4 : active;
  endfunction

  function automatic logic pd_of(input bit sel);
    return sel ? per_done4 : per_done;
  endfunction

  task automatic applyStimulus(input bit sel, input logic r, input logic [3:0] n);
    if (sel) begin
      run4 = r;
      notenum4 = n;
    end else begin
      run = r;
      notenum = n;
    end
  endtask

  task automatic steps(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset(input bit sel);
    if (sel) clr4 = 1'b1;
    else clr = 1'b1;
    applyStimulus(sel, 1'b0, 4'd0);
    steps(2);
    checkOutput("reset_pz", int'(pz_of(sel)), 0);
    checkOutput("reset_active", int'(act_of(sel)), 0);
    checkOutput("reset_per_done", int'(pd_of(sel)), 0);
    if (sel) clr4 = 1'b0;
    else clr = 1'b0;
  endtask

  task automatic wait_rise(input bit sel, input int bound, output int waited);
    waited = 0;
    while (pz_of(sel) !== 1'b1 && waited < bound) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Counts consecutive sampled cycles with pz at lvl while the tone is active.
  task automatic run_len(input bit sel, input logic lvl, input int bound, output int len);
    len = 0;
    while (pz_of(sel) === lvl && act_of(sel) === 1'b1 && len < bound) begin
      @(negedge clk);
      len++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int w, len, bad;

    vecs[0] = '{1'b1, 4'd0,  0};
    vecs[1] = '{1'b1, 4'd14, 0};
    vecs[2] = '{1'b1, 4'd15, 0};
    vecs[3] = '{1'b0, 4'd5,  0};
    vecs[4] = '{1'b1, 4'd1,  1911};
    vecs[5] = '{1'b1, 4'd5,  1517};
    vecs[6] = '{1'b1, 4'd7,  1351};
    vecs[7] = '{1'b1, 4'd10, 1136};
    vecs[8] = '{1'b1, 4'd13, 956};

    clr = 1'b1; run = 1'b0; notenum = 4'd0;
    clr4 = 1'b1; run4 = 1'b0; notenum4 = 4'd0;
    steps(2);

    // Quiet after reset with run low.
    do_reset(0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pz || active || per_done) bad++;
    end
    checkOutput("idle_100_cycles", bad, 0);

    // Table: rest codes stay silent, valid notes give exact half-periods.
    for (int i = 0; i < 9; i++) begin
      do_reset(0);
      applyStimulus(0, vecs[i].run, vecs[i].notenum);
      if (vecs[i].half == 0) begin
        steps(10);
        checkOutput($sformatf("vec%0d_idle_pz", i), int'(pz), 0);
        checkOutput($sformatf("vec%0d_idle_active", i), int'(active), 0);
      end else begin
        wait_rise(0, 10, w);
        checkOutput($sformatf("vec%0d_latency", i), w, 1);
        checkOutput($sformatf("vec%0d_active", i), int'(active), 1);
        run_len(0, 1'b1, 4000, len);
        checkOutput($sformatf("vec%0d_high", i), len, vecs[i].half);
        applyStimulus(0, 1'b0, vecs[i].notenum);
        run_len(0, 1'b0, 4000, len);
        checkOutput($sformatf("vec%0d_low", i), len, vecs[i].half);
        checkOutput($sformatf("vec%0d_end_per_done", i), int'(per_done), 1);
        checkOutput($sformatf("vec%0d_end_active", i), int'(active), 0);
      end
    end

    // Continuous note 10, then switch to note 1 mid-high: no truncated half.
    do_reset(0);
    applyStimulus(0, 1'b1, 4'd10);
    wait_rise(0, 10, w);
    checkOutput("sw_latency", w, 1);
    run_len(0, 1'b1, 4000, len);
    checkOutput("sw_high1", len, 1136);
    run_len(0, 1'b0, 4000, len);
    checkOutput("sw_low1", len, 1136);
    checkOutput("sw_per_done1", int'(per_done), 1);
    checkOutput("sw_no_gap_pz", int'(pz), 1);
    steps(1);
    checkOutput("sw_per_done1_width", int'(per_done), 0);
    steps(499);
    applyStimulus(0, 1'b1, 4'd1);
    run_len(0, 1'b1, 4000, len);
    checkOutput("sw_high2_rest", len, 636);
    run_len(0, 1'b0, 4000, len);
    checkOutput("sw_low2_old_pitch", len, 1136);
    checkOutput("sw_per_done2", int'(per_done), 1);
    run_len(0, 1'b1, 4000, len);
    checkOutput("sw_high3_new_pitch", len, 1911);
    applyStimulus(0, 1'b0, 4'd1);
    run_len(0, 1'b0, 4000, len);
    checkOutput("sw_low3_new_pitch", len, 1911);
    checkOutput("sw_stop_active", int'(active), 0);

    // Run dropped 100 cycles into note 13: period completes, single pulse, idle.
    do_reset(0);
    applyStimulus(0, 1'b1, 4'd13);
    wait_rise(0, 10, w);
    steps(100);
    applyStimulus(0, 1'b0, 4'd13);
    run_len(0, 1'b1, 4000, len);
    checkOutput("drop_high_rest", len, 856);
    run_len(0, 1'b0, 4000, len);
    checkOutput("drop_low", len, 956);
    checkOutput("drop_per_done", int'(per_done), 1);
    checkOutput("drop_active", int'(active), 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pz || active || per_done) bad++;
    end
    checkOutput("drop_quiet_after", bad, 0);

    // Rest codes while running, then a valid note.
    do_reset(0);
    applyStimulus(0, 1'b1, 4'd0);
    steps(20);
    applyStimulus(0, 1'b1, 4'd14);
    steps(20);
    applyStimulus(0, 1'b1, 4'd15);
    steps(20);
    checkOutput("rest_pz", int'(pz), 0);
    checkOutput("rest_active", int'(active), 0);
    applyStimulus(0, 1'b1, 4'd5);
    wait_rise(0, 10, w);
    checkOutput("rest_then5_latency", w, 1);
    run_len(0, 1'b1, 4000, len);
    checkOutput("rest_then5_high", len, 1517);
    applyStimulus(0, 1'b0, 4'd5);
    run_len(0, 1'b0, 4000, len);
    checkOutput("rest_then5_low", len, 1517);

    // DIV=4: prescaled half-periods, then reset mid-high and restart.
    do_reset(1);
    applyStimulus(1, 1'b1, 4'd13);
    wait_rise(1, 20, w);
    checkOutput("div4_latency", w, 4);
    run_len(1, 1'b1, 8000, len);
    checkOutput("div4_high", len, 3824);
    run_len(1, 1'b0, 8000, len);
    checkOutput("div4_low", len, 3824);
    checkOutput("div4_per_done", int'(per_done4), 1);
    steps(1);
    checkOutput("div4_per_done_width", int'(per_done4), 0);
    steps(49);
    clr4 = 1'b1;
    steps(1);
    checkOutput("div4_clr_pz", int'(pz4), 0);
    checkOutput("div4_clr_active", int'(active4), 0);
    clr4 = 1'b0;
    wait_rise(1, 20, w);
    checkOutput("div4_restart_latency", w, 4);
    run_len(1, 1'b1, 8000, len);
    checkOutput("div4_restart_high", len, 3824);
    applyStimulus(1, 1'b0, 4'd13);
    run_len(1, 1'b0, 8000, len);
    checkOutput("div4_restart_low", len, 3824);
    checkOutput("div4_restart_stop", int'(active4), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
